iadc_conv_ctrl: RTL and testbench
=================================

Name: iadc_conv_ctrl

Overview:
- Conversion sequencer and result holding stage directly downstream of the decimator in the incremental ADC.
- Resets the modulator integrators and the decimator at the start of each conversion, then counts OSR modulator clocks.
- At the end of the count it captures the decimator output into a result register and presents it on a valid/ready handshake to the digital back end.
- Supports single-shot and continuous conversion modes.

Parameters:
- DATA_W, 12: width of the decimator output and of the result.
- OSR, 512: modulator clocks per conversion (integrate phase length), range 2..65535.
- RST_CYC, 2: clocks for which the modulator/decimator reset is held at conversion start, range 1..15.

Ports:
- clk  input  1  system/modulator clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle request to begin a conversion; ignored unless in IDLE.
- continuous  input  1  when 1, a new conversion begins automatically after each capture; sampled in CAPTURE.
- stop  input  1  returns to IDLE from any state within one clock; no capture is made.
- dec_data  input  DATA_W  decimator data_out.
- dec_rst_n  output  1  active-low reset to the decimator.
- mod_rst  output  1  active-high integrator reset to the modulator.
- busy  output  1  high in every state except IDLE.
- result  output  DATA_W  captured conversion result.
- result_valid  output  1  result holds an unconsumed value.
- result_ready  input  1  consumer accepts when result_valid && result_ready at a rising edge.
- overrun  output  1  sticky: a capture was dropped because the prior result was unconsumed.
- clear_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async assert) forces:
  - state=IDLE, counter=0
  - dec_rst_n=0, mod_rst=1, busy=0
  - result=0, result_valid=0, overrun=0
- Reset release is used synchronously.
- State machine (Moore outputs registered):
  - IDLE: dec_rst_n=0, mod_rst=1. start=1 -> RESET, counter cleared.
  - RESET: dec_rst_n=0, mod_rst=1 for exactly RST_CYC clocks. Then -> INTEGRATE, counter=0.
  - INTEGRATE: dec_rst_n=1, mod_rst=0. Counter increments each clock. Stays exactly OSR clocks, i.e. leaves when counter==OSR-1, -> CAPTURE.
  - CAPTURE (1 clock): dec_rst_n=1. dec_data is sampled on the edge leaving CAPTURE. Then -> RESET if continuous=1, else -> IDLE.
- Timing from start: start seen at edge E; busy=1 after E; capture edge = E + RST_CYC + OSR + 1.
- Result register and handshake:
  - Capture with result_valid=0: result<=dec_data, result_valid<=1.
  - Capture with result_valid=1 and result_ready=1 on the same edge: new value loads, result_valid stays 1, no overrun.
  - Capture with result_valid=1 and result_ready=0: result unchanged (old value kept), new sample dropped, overrun<=1.
  - Accept with no capture on that edge: result_valid<=0; result holds its value.
  - result is stable while result_valid=1 and result_ready=0.
- overrun:
  - Cleared only by rst or clear_ovr.
  - clear_ovr on the same edge as a new overrun: set wins.
- stop:
  - Has priority over start and over state transitions.
  - Next state is IDLE, counter=0.
  - result/result_valid are unaffected, except that a CAPTURE-state edge with stop=1 performs no capture.
- start while busy is ignored; it does not queue.
- Counter width is clog2(OSR)+1; it never wraps within a conversion.
- Async reset mid-conversion aborts immediately with the outputs listed above.

Test Plan:
- Single shot, OSR=512, RST_CYC=2, dec_data driven by a model that counts clocks while dec_rst_n=1 -> one capture at E+515, result=513 (512 INTEGRATE + 1 CAPTURE clocks), result_valid=1, busy=0 afterwards, dec_rst_n=0 in IDLE.
- Continuous mode with result_ready=1 held -> captures every 515 clocks, each result=513, overrun stays 0. Drop continuous -> IDLE after the next capture.
- Continuous mode with result_ready=0 -> second capture sets overrun=1 and result keeps the first value. clear_ovr pulse -> overrun=0.
- Capture and accept on the same edge -> result_valid stays 1, result updates to the new value, overrun=0.
- stop asserted at INTEGRATE counter=100 -> IDLE next clock, dec_rst_n=0, mod_rst=1, no result_valid change. start during busy is ignored (capture time unchanged).
- Async rst pulse mid-INTEGRATE (between edges) -> all outputs at reset values immediately. After release, start performs a normal conversion.

Source files
------------

// File: rtl/iadc_conv_ctrl.sv
// rtl/iadc_conv_ctrl.sv - incremental ADC conversion sequencer and result holding stage
//
// Purpose:
//   Sequences one incremental-ADC conversion: holds the modulator and the
//   decimator in reset for RST_CYC clocks, lets them integrate for OSR clocks,
//   then spends one CAPTURE clock and samples the decimator output on the edge
//   leaving CAPTURE. The captured value is held in a result register and
//   offered to the back end on a valid/ready handshake. In continuous mode a
//   new conversion starts right after each capture.
//
// Ports:
//   clk           system/modulator clock, rising edge
//   rst           asynchronous active-high reset
//   start         one-cycle conversion request, honoured only in IDLE
//   continuous    restart automatically after capture (sampled in CAPTURE)
//   stop          abort to IDLE within one clock, no capture
//   dec_data      decimator output
//   dec_rst_n     active-low decimator reset
//   mod_rst       active-high modulator integrator reset
//   busy          high whenever not IDLE
//   result        captured conversion result
//   result_valid  result holds an unconsumed value
//   result_ready  consumer accepts on result_valid && result_ready
//   overrun       sticky flag: a capture was dropped (prior result unconsumed)
//   clear_ovr     synchronous clear of overrun (a new overrun wins)

module iadc_conv_ctrl #(
  parameter int DATA_W  = 12,
  parameter int OSR     = 512,
  parameter int RST_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic [DATA_W-1:0] dec_data,
  output logic              dec_rst_n,
  output logic              mod_rst,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overrun,
  input  logic              clear_ovr
);

  // One extra bit so the integrate counter can never wrap inside a conversion.
  localparam int CNT_W = $clog2(OSR) + 1;
  localparam logic [CNT_W-1:0] OSR_LAST = CNT_W'(OSR - 1);
  // RESET-phase length is bounded by 15, so it gets its own 4-bit counter;
  // this keeps small OSR values (narrow main counter) from limiting RST_CYC.
  localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_INTEG = 2'd2,
    S_CAPT  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic [3:0]       rcnt;
  logic [3:0]       next_rcnt;

  logic             next_dec_rst_n;
  logic             next_mod_rst;
  logic             next_busy;

  logic             capture;
  logic             accept;
  logic             drop;

  // ------------------------------------------------------------------
  // State and counter registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rcnt  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      rcnt  <= next_rcnt;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic; stop overrides every other transition
  // ------------------------------------------------------------------
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_rcnt  = rcnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_RESET;
          next_cnt   = '0;
          next_rcnt  = '0;
        end
      end

      S_RESET: begin
        if (rcnt == RST_LAST) begin
          next_state = S_INTEG;
          next_cnt   = '0;
          next_rcnt  = '0;
        end else begin
          next_rcnt = rcnt + 4'd1;
        end
      end

      S_INTEG: begin
        // counter==OSR-1 marks the last of exactly OSR integrate clocks
        if (cnt == OSR_LAST) begin
          next_state = S_CAPT;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end

      S_CAPT: begin
        next_cnt  = '0;
        next_rcnt = '0;
        if (continuous) begin
          next_state = S_RESET;
        end else begin
          next_state = S_IDLE;
        end
      end

      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
        next_rcnt  = '0;
      end
    endcase

    if (stop) begin
      next_state = S_IDLE;
      next_cnt   = '0;
      next_rcnt  = '0;
    end
  end

  // ------------------------------------------------------------------
  // Moore outputs, decoded from the next state so the registered copies
  // line up with the state register after every edge.
  // ------------------------------------------------------------------
  always_comb begin
    next_dec_rst_n = 1'b0;
    next_mod_rst   = 1'b1;
    next_busy      = 1'b1;
    case (next_state)
      S_IDLE: begin
        next_dec_rst_n = 1'b0;
        next_mod_rst   = 1'b1;
        next_busy      = 1'b0;
      end
      S_RESET: begin
        next_dec_rst_n = 1'b0;
        next_mod_rst   = 1'b1;
      end
      S_INTEG: begin
        next_dec_rst_n = 1'b1;
        next_mod_rst   = 1'b0;
      end
      S_CAPT: begin
        next_dec_rst_n = 1'b1;
        next_mod_rst   = 1'b0;
      end
      default: begin
        next_dec_rst_n = 1'b0;
        next_mod_rst   = 1'b1;
        next_busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_rst_n <= 1'b0;
      mod_rst   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      dec_rst_n <= next_dec_rst_n;
      mod_rst   <= next_mod_rst;
      busy      <= next_busy;
    end
  end

  // ------------------------------------------------------------------
  // Result register and handshake
  // ------------------------------------------------------------------
  // A stop on the CAPTURE edge suppresses the capture entirely.
  assign capture = (state == S_CAPT) && !stop;
  assign accept  = result_valid && result_ready;
  // Dropped sample: old value still owned by the consumer and not taken now.
  assign drop    = capture && result_valid && !result_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (capture && !drop) begin
        result       <= dec_data;
        result_valid <= 1'b1;
      end else if (accept && !capture) begin
        result_valid <= 1'b0;
      end
    end
  end

  // Sticky overrun; a new drop beats clear_ovr on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iadc_conv_ctrl.sv
// tb/tb_iadc_conv_ctrl.sv - self-checking bench for iadc_conv_ctrl

module tb_iadc_conv_ctrl;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          continuous;
  logic          stop;
  logic [DW-1:0] dec_data;
  logic          dec_rst_n;
  logic          mod_rst;
  logic          busy;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          overrun;
  logic          clear_ovr;

  int total = 0;
  int bad   = 0;

  // Decimator stand-in: counts falling edges while released from reset,
  // plus a per-conversion offset so old and new captures are distinguishable.
  logic [DW-1:0] dec_cnt;
  logic [DW-1:0] dec_ofs;
  assign dec_data = dec_cnt + dec_ofs;

  always @(negedge clk) begin
    if (!dec_rst_n) dec_cnt <= '0;
    else            dec_cnt <= dec_cnt + 12'd1;
  end

  always #5 clk = ~clk;

  iadc_conv_ctrl #(.DATA_W(DW), .OSR(512), .RST_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .stop         (stop),
    .dec_data     (dec_data),
    .dec_rst_n    (dec_rst_n),
    .mod_rst      (mod_rst),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overrun      (overrun),
    .clear_ovr    (clear_ovr)
  );

  typedef struct {
    logic [DW-1:0] ofs;
    logic          rdy;
    logic          clr;
    logic [DW-1:0] exp_res;
    logic          exp_val;
    logic          exp_ovr;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1ns after the edge E on which start was seen.
  task automatic pulse_start();
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
  endtask

  task automatic consume();
    result_ready = 1'b1;
    wait_edges(1);
    result_ready = 1'b0;
  endtask

  logic [DW-1:0] prev_res;

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
    result_ready = 1'b0; clear_ovr = 1'b0; dec_ofs = '0;

    vt[0] = '{ofs: 12'd0,   rdy: 1'b0, clr: 1'b0, exp_res: 12'd513, exp_val: 1'b1, exp_ovr: 1'b0};
    vt[1] = '{ofs: 12'd100, rdy: 1'b1, clr: 1'b0, exp_res: 12'd613, exp_val: 1'b1, exp_ovr: 1'b0};
    vt[2] = '{ofs: 12'd200, rdy: 1'b0, clr: 1'b0, exp_res: 12'd613, exp_val: 1'b1, exp_ovr: 1'b1};
    vt[3] = '{ofs: 12'd300, rdy: 1'b0, clr: 1'b1, exp_res: 12'd613, exp_val: 1'b1, exp_ovr: 1'b1};
    vt[4] = '{ofs: 12'd400, rdy: 1'b1, clr: 1'b1, exp_res: 12'd913, exp_val: 1'b1, exp_ovr: 1'b0};

    wait_edges(3);
    chk("rst_busy",      busy,         0);
    chk("rst_dec_rst_n", dec_rst_n,    0);
    chk("rst_mod_rst",   mod_rst,      1);
    chk("rst_result",    result,       0);
    chk("rst_valid",     result_valid, 0);
    chk("rst_overrun",   overrun,      0);
    rst = 1'b0;
    wait_edges(2);

    // Single-shot conversions exercising each capture/handshake combination.
    prev_res = '0;
    for (int i = 0; i < 5; i++) begin
      dec_ofs = vt[i].ofs;
      pulse_start();
      chk($sformatf("v%0d_busy_after_start", i), busy, 1);
      wait_edges(2);
      chk($sformatf("v%0d_integ_dec_rst_n", i), dec_rst_n, 1);
      chk($sformatf("v%0d_integ_mod_rst", i),   mod_rst,   0);
      wait_edges(512);
      chk($sformatf("v%0d_pre_cap_result", i), result, prev_res);
      chk($sformatf("v%0d_pre_cap_busy", i),   busy,   1);
      result_ready = vt[i].rdy;
      clear_ovr    = vt[i].clr;
      wait_edges(1);
      result_ready = 1'b0;
      clear_ovr    = 1'b0;
      chk($sformatf("v%0d_result", i),    result,       vt[i].exp_res);
      chk($sformatf("v%0d_valid", i),     result_valid, vt[i].exp_val);
      chk($sformatf("v%0d_overrun", i),   overrun,      vt[i].exp_ovr);
      chk($sformatf("v%0d_busy", i),      busy,         0);
      chk($sformatf("v%0d_dec_rst_n", i), dec_rst_n,    0);
      chk($sformatf("v%0d_mod_rst", i),   mod_rst,      1);
      prev_res = vt[i].exp_res;
      wait_edges(2);
    end

    // Accept without capture: valid drops, value holds.
    consume();
    chk("accept_valid",  result_valid, 0);
    chk("accept_result", result,       913);

    // Continuous with ready held high: every capture loads, no overrun.
    dec_ofs = '0; continuous = 1'b1; result_ready = 1'b1;
    pulse_start();
    wait_edges(515);
    chk("cont_cap1_result", result,       513);
    chk("cont_cap1_valid",  result_valid, 1);
    chk("cont_cap1_busy",   busy,         1);
    dec_ofs = 12'd7;
    wait_edges(514);
    chk("cont_pre_cap2_valid", result_valid, 0);
    wait_edges(1);
    chk("cont_cap2_result",  result,       520);
    chk("cont_cap2_valid",   result_valid, 1);
    chk("cont_cap2_overrun", overrun,      0);
    continuous = 1'b0;
    wait_edges(514);
    chk("cont_pre_cap3_busy", busy, 1);
    wait_edges(1);
    result_ready = 1'b0;
    chk("cont_cap3_result", result,  520);
    chk("cont_cap3_busy",   busy,    0);
    chk("cont_cap3_ovr",    overrun, 0);
    wait_edges(3);
    chk("cont_stays_idle", busy, 0);

    // Continuous with ready low: second capture dropped, overrun set.
    consume();
    dec_ofs = '0; continuous = 1'b1;
    pulse_start();
    wait_edges(515);
    chk("ovr_cap1_result", result,       513);
    chk("ovr_cap1_valid",  result_valid, 1);
    dec_ofs = 12'd50;
    wait_edges(515);
    chk("ovr_cap2_result",  result,  513);
    chk("ovr_cap2_overrun", overrun, 1);
    stop = 1'b1; continuous = 1'b0;
    wait_edges(1);
    stop = 1'b0;
    chk("ovr_stop_busy", busy, 0);
    clear_ovr = 1'b1;
    wait_edges(1);
    clear_ovr = 1'b0;
    chk("ovr_cleared",       overrun,      0);
    chk("ovr_clear_valid",   result_valid, 1);
    chk("ovr_clear_result",  result,       513);

    // stop at INTEGRATE counter==100.
    dec_ofs = '0;
    pulse_start();
    wait_edges(102);
    chk("stop_pre_dec_rst_n", dec_rst_n, 1);
    stop = 1'b1;
    wait_edges(1);
    stop = 1'b0;
    chk("stop_busy",      busy,         0);
    chk("stop_dec_rst_n", dec_rst_n,    0);
    chk("stop_mod_rst",   mod_rst,      1);
    chk("stop_valid",     result_valid, 1);
    chk("stop_result",    result,       513);

    // start while busy must not shift or queue a conversion.
    consume();
    dec_ofs = 12'd3;
    pulse_start();
    wait_edges(48);
    pulse_start();
    wait_edges(465);
    chk("busy_start_pre_cap_valid", result_valid, 0);
    wait_edges(1);
    chk("busy_start_cap_valid",  result_valid, 1);
    chk("busy_start_cap_result", result,       516);
    wait_edges(3);
    chk("busy_start_no_queue", busy, 0);

    // Async reset between edges mid-INTEGRATE.
    dec_ofs = '0;
    pulse_start();
    wait_edges(200);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",      busy,         0);
    chk("arst_dec_rst_n", dec_rst_n,    0);
    chk("arst_mod_rst",   mod_rst,      1);
    chk("arst_result",    result,       0);
    chk("arst_valid",     result_valid, 0);
    chk("arst_overrun",   overrun,      0);
    #3 rst = 1'b0;
    wait_edges(2);
    pulse_start();
    wait_edges(514);
    chk("post_rst_pre_cap_valid", result_valid, 0);
    wait_edges(1);
    chk("post_rst_result", result,       513);
    chk("post_rst_valid",  result_valid, 1);
    chk("post_rst_busy",   busy,         0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
